icache_refill: RTL

//  Miss-refill engine for the I-cache: on a miss it issues one AXI4 INCR read burst for the 64-byte line
//  and streams each 32-bit beat into the 4x128-bit data SRAM banks as burst_count/wmask/line_wdata/wen.
//  It is the write side of the I-cache data array; fetch reads the array. The tag is written on success.

---
 rtl/icache_refill_pkg.sv | 28 ++
 rtl/icache_refill.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_pkg
//   Shared definitions for the I-cache refill engine:
//     - default geometry (index / offset / address widths) and the derived TAG_LEN
//     - refill FSM state encoding
//     - AXI4 read-burst constants used for a 64-byte line fetch
// -----------------------------------------------------------------------------
package icache_refill_pkg;

   localparam int IDX_LEN_DEF = 7;
   localparam int BLK_LEN_DEF = 6;
   localparam int ADDR_W_DEF  = 32;
   localparam int TAG_LEN     = ADDR_W_DEF - IDX_LEN_DEF - BLK_LEN_DEF;

   // One 64-byte line = 16 beats of 4 bytes, incrementing burst.
   localparam logic [7:0] AXI_LEN_LINE   = 8'd15;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_AR    = 2'd1,
      ST_RDATA = 2'd2,
      ST_DONE  = 2'd3
   } refill_state_e;

endpackage

// File: rtl/icache_refill.sv
// -----------------------------------------------------------------------------
// icache_refill
//   Miss-refill engine for the I-cache data array. On a miss it issues one AXI4
//   INCR burst (16 x 32-bit) for the line and streams every beat into the
//   4 x 128-bit data SRAM banks, one write strobe per beat, the cycle after the
//   beat is accepted. The tag/valid write is issued once the line completes
//   without any response or rlast error.
//
//   Optional feature macro: ICACHE_REFILL_FWD_EN (early-restart forwarding of
//   the critical word on fwd_valid_o / fwd_data_o).
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   miss_req_i, miss_addr_i    refill request and missing address (IDLE only)
//   busy_o                     engine not idle
//   refill_done_o/_err_o       1-cycle completion pulse and its error flag
//   ar*                        AXI read address channel (constant burst shape)
//   r*                         AXI read data channel
//   icache_index_o             set being refilled
//   burst_count_o              beat number: [3:2] bank, [1:0] word in row
//   icache_line_wdata_o        beat data replicated into all four lanes
//   icache_wmask_o             all-ones in the lane of the current word
//   icache_wen_o               data-array write strobe
//   tag_wen_o, tag_o           tag/valid write pulse and tag value
//   fwd_valid_o, fwd_data_o    (ICACHE_REFILL_FWD_EN only) critical word
// -----------------------------------------------------------------------------
module icache_refill
   import icache_refill_pkg::*;
#(
   parameter  int IDX_LEN = IDX_LEN_DEF,
   parameter  int BLK_LEN = BLK_LEN_DEF,
   parameter  int ADDR_W  = ADDR_W_DEF,
   localparam int TAG_W   = ADDR_W - IDX_LEN - BLK_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                miss_req_i,
   input  logic [ADDR_W-1:0]   miss_addr_i,
   output logic                busy_o,
   output logic                refill_done_o,
   output logic                refill_err_o,
   output logic                arvalid_o,
   input  logic                arready_i,
   output logic [ADDR_W-1:0]   araddr_o,
   output logic [7:0]          arlen_o,
   output logic [2:0]          arsize_o,
   output logic [1:0]          arburst_o,
   input  logic                rvalid_i,
   output logic                rready_o,
   input  logic [31:0]         rdata_i,
   input  logic [1:0]          rresp_i,
   input  logic                rlast_i,
   output logic [IDX_LEN-1:0]  icache_index_o,
   output logic [3:0]          burst_count_o,
   output logic [127:0]        icache_line_wdata_o,
   output logic [127:0]        icache_wmask_o,
   output logic                icache_wen_o,
   output logic                tag_wen_o,
   output logic [TAG_W-1:0]    tag_o
`ifdef ICACHE_REFILL_FWD_EN
  ,output logic                fwd_valid_o,
   output logic [31:0]         fwd_data_o
`endif
);

   function automatic logic [127:0] lane_mask(input logic [1:0] lane);
      return 128'(32'hFFFF_FFFF) << {lane, 5'b00000};
   endfunction

   function automatic logic [127:0] lane_repl(input logic [31:0] d);
      return {4{d}};
   endfunction

   refill_state_e state_q, state_d;

   logic [ADDR_W-BLK_LEN-1:0] line_q;
   logic [3:0]  cnt_q;
   logic        err_q;
   logic        fin_p1;
   logic        vld_p1;
   logic [3:0]  beat_p1;
   logic [31:0] data_p1;

   logic accept_req;
   logic beat_fire;
   logic beat_last;
   logic beat_err;

   // Offset bits are not needed for a line fetch (beyond the critical word).
   logic unused_addr_bits;
   assign unused_addr_bits = ^miss_addr_i[BLK_LEN-1:0];

   assign accept_req = (state_q == ST_IDLE) && miss_req_i;
   // Once the final beat is registered, stop accepting beats while it is written.
   assign beat_fire  = (state_q == ST_RDATA) && !fin_p1 && rvalid_i;
   assign beat_last  = rlast_i || (cnt_q == 4'd15);
   // rlast must coincide exactly with beat 15.
   assign beat_err   = (rresp_i != AXI_RESP_OKAY) || (rlast_i != (cnt_q == 4'd15));

   // ---- stage p0 -> p1: control state and beat capture ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         fin_p1  <= 1'b0;
         vld_p1  <= 1'b0;
      end else begin
         state_q <= state_d;
         vld_p1  <= beat_fire;
         if (accept_req) begin
            cnt_q  <= 4'd0;
            err_q  <= 1'b0;
            fin_p1 <= 1'b0;
         end else if (beat_fire) begin
            if (cnt_q != 4'd15) cnt_q <= cnt_q + 4'd1;
            if (beat_err)       err_q <= 1'b1;
            fin_p1 <= beat_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept_req) line_q <= miss_addr_i[ADDR_W-1:BLK_LEN];
      if (beat_fire) begin
         data_p1 <= rdata_i;
         beat_p1 <= cnt_q;
      end
   end

`ifdef ICACHE_REFILL_FWD_EN
   logic [3:0] crit_q;
   logic       fwd_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_p1 <= 1'b0;
      end else begin
         // Forward only if no earlier beat has already flagged an error.
         fwd_p1 <= beat_fire && (cnt_q == crit_q) && !err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (accept_req) crit_q <= miss_addr_i[BLK_LEN-1:2];
   end

   assign fwd_valid_o = fwd_p1;
   assign fwd_data_o  = fwd_p1 ? data_p1 : 32'd0;
`endif

   // ---- next state / outputs ----
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (miss_req_i) state_d = ST_AR;
         ST_AR:    if (arready_i)  state_d = ST_RDATA;
         ST_RDATA: if (fin_p1)     state_d = ST_DONE;
         ST_DONE:                  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o              = (state_q != ST_IDLE);
      arvalid_o           = (state_q == ST_AR);
      rready_o            = (state_q == ST_RDATA) && !fin_p1;
      refill_done_o       = (state_q == ST_DONE);
      refill_err_o        = (state_q == ST_DONE) && err_q;
      tag_wen_o           = (state_q == ST_DONE) && !err_q;
      araddr_o            = {line_q, {BLK_LEN{1'b0}}};
      arlen_o             = AXI_LEN_LINE;
      arsize_o            = AXI_SIZE_4B;
      arburst_o           = AXI_BURST_INCR;
      icache_index_o      = line_q[IDX_LEN-1:0];
      tag_o               = line_q[ADDR_W-BLK_LEN-1:IDX_LEN];
      icache_wen_o        = vld_p1;
      burst_count_o       = 4'd0;
      icache_line_wdata_o = 128'd0;
      icache_wmask_o      = 128'd0;
      if (vld_p1) begin
         burst_count_o       = beat_p1;
         icache_line_wdata_o = lane_repl(data_p1);
         icache_wmask_o      = lane_mask(beat_p1[1:0]);
      end
   end

endmodule
